// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // RUN: normal flow. MEM_WAIT: a data-memory access is outstanding.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detection: does the ID instruction read the
// register that the load sitting in ID/EX is about to write?
module load_use_detector
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  output logic                  hazard
);

  logic rs_match;
  logic rt_match;

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    rs_match = id_uses_rs && (id_rs_addr == ex_rt_addr);
    rt_match = id_uses_rt && (id_rt_addr == ex_rt_addr);
    hazard   = ex_mem_read && (ex_rt_addr != REG_ZERO) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the five-stage pipeline. Decisions are
// combinational from the current state and inputs; state, the wait counter,
// the performance counters and the sticky timeout flag are registered.
// Priority: memory wait > taken branch > load-use > none.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
  output logic                  mem_timeout_err,
  output state_t                dbg_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state_q;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_wait;
  logic              branch_resp;

  load_use_detector u_load_use_detector (
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt_addr  (ex_rt_addr),
    .hazard      (load_use)
  );

  assign dbg_state = state_q;

  // State register; reset mid-wait drops straight back to RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  // Next state and the prioritised stall/flush decision. In the release
  // cycle (MEM_WAIT with dmem_ready) the wait drops and the branch and
  // load-use rules apply as usual; a branch held in a frozen EX during the
  // wait is therefore acted on exactly then.
  always_comb begin
    state_nxt    = state_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    branch_resp  = 1'b0;
    mem_wait     = 1'b0;

    case (state_q)
      RUN: begin
        mem_wait = mem_access && !dmem_ready;
        if (mem_wait) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_wait = !dmem_ready;
        if (dmem_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    if (!reset) begin
      state_nxt = RUN;
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The consumer in ID is squashed, so any load-use stall is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_resp = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Consecutive not-ready cycles in MEM_WAIT; sets the sticky timeout flag
  // on the edge the count reaches MEM_TIMEOUT without aborting the wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else if (state_nxt == RUN) begin
      wait_cnt <= '0;
    end else if (state_q == MEM_WAIT) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_ONE;
      if (wait_cnt == WAIT_LAST) mem_timeout_err <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1))    stall_cycles <= stall_cycles + CNT_ONE;
      if (branch_resp && (flush_events != '1)) flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a vector table for the
// single-cycle decisions, then hand sequences for waits, timeout, reset and
// counter saturation.
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int SAT   = 15;

  // Output packing: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  //                  id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_BR   = 7'b0010100;
  localparam logic [6:0] O_MW   = 7'b1101011;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs_addr, id_rt_addr, ex_rt_addr;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic          mem_access, dmem_ready;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic          id_ex_flush, ex_mem_stall, mem_wb_flush;
  logic [CW-1:0] stall_cycles, flush_events;
  logic          mem_timeout_err;
  state_t        dbg_state;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt_addr      (ex_rt_addr),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_flush    (mem_wb_flush),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mem_timeout_err (mem_timeout_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       ma;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mr,
                              input logic [4:0] ert, input logic br,
                              input logic ma, input logic rdy,
                              input logic [6:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
    v.ert = ert; v.br = br; v.ma = ma; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_stall = 0;
  int         exp_flush = 0;

  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
            id_ex_flush, ex_mem_stall, mem_wb_flush};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic br,
                       input logic ma, input logic rdy);
    id_rs_addr = rs; id_rt_addr = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt_addr = ert; ex_branch_taken = br;
    mem_access = ma; dmem_ready = rdy;
  endtask

  task automatic drive_idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare the decision mid-cycle, update the counter model, then step.
  task automatic expect_cycle(input string name, input logic [6:0] exp);
    logic [6:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, 32'(outs()), 32'(e));
    if (e[6] && exp_stall < SAT) exp_stall++;
    if (e[4] && exp_flush < SAT) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(5'd5, 5'd2, 1, 1, 1, 5'd5, 0, 0, 0, O_LU);   // rs hit
    vecs[1]  = mk(5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0, O_LU);   // rt hit
    vecs[2]  = mk(5'd5, 5'd3, 0, 1, 1, 5'd5, 0, 0, 0, O_NONE); // rs not read
    vecs[3]  = mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, O_NONE); // load to $0
    vecs[4]  = mk(5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, O_NONE); // not a load
    vecs[5]  = mk(5'd5, 5'd2, 1, 1, 1, 5'd5, 1, 0, 0, O_BR);   // branch beats load-use
    vecs[6]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, O_BR);   // branch alone
    vecs[7]  = mk(5'd9, 5'd2, 1, 0, 1, 5'd9, 0, 1, 1, O_LU);   // ready access, no wait
    vecs[8]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, O_BR);   // ready access + branch
    vecs[9]  = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_NONE); // idle
    vecs[10] = mk(5'd7, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, O_LU);   // both sources hit
    vecs[11] = mk(5'd6, 5'd4, 1, 1, 1, 5'd5, 0, 0, 0, O_NONE); // different regs

    // Reset state, with a not-ready access on the inputs to show forcing.
    drive_idle();
    mem_access = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'(O_NONE));
    check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check("reset_flush_cnt", 32'(flush_events), 32'd0);
    check("reset_err", 32'(mem_timeout_err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(RUN));
    drive_idle();
    reset = 1'b1;

    // Table of single-cycle decisions in RUN.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mr,
            vecs[i].ert, vecs[i].br, vecs[i].ma, vecs[i].rdy);
      expect_cycle($sformatf("vec%0d", i), vecs[i].exp);
    end
    check("table_stall_cnt", 32'(stall_cycles), 32'(exp_stall));
    check("table_flush_cnt", 32'(flush_events), 32'(exp_flush));
    check("table_state", 32'(dbg_state), 32'(RUN));

    // Load-use lasts one cycle: the load moves on and the hazard clears.
    do_reset();
    drive(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
    expect_cycle("lu_stall", O_LU);
    drive(5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0);
    expect_cycle("lu_after", O_NONE);
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Memory wait: not ready in the request cycle plus 3 wait cycles.
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    expect_cycle("mw_first", O_MW);
    check("mw_state", 32'(dbg_state), 32'(MEM_WAIT));
    for (int k = 0; k < 3; k++) expect_cycle($sformatf("mw_wait%0d", k), O_MW);
    dmem_ready = 1'b1;
    expect_cycle("mw_release", O_NONE);
    check("mw_back_run", 32'(dbg_state), 32'(RUN));
    check("mw_stall_cnt", 32'(stall_cycles), 32'd5);
    drive_idle();

    // Branch held in a frozen EX during a 2-cycle wait fires on release.
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    expect_cycle("bw_first", O_MW);
    expect_cycle("bw_wait0", O_MW);
    expect_cycle("bw_wait1", O_MW);
    dmem_ready = 1'b1;
    expect_cycle("bw_release", O_BR);
    drive_idle();
    check("bw_flush_cnt", 32'(flush_events), 32'd1);
    check("bw_stall_cnt", 32'(stall_cycles), 32'(exp_stall));

    // Timeout: flag sets after the 4th MEM_WAIT cycle and stays set.
    do_reset();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    expect_cycle("to_first", O_MW);
    for (int k = 1; k <= 6; k++) begin
      expect_cycle($sformatf("to_wait%0d", k), O_MW);
      check($sformatf("to_err%0d", k), 32'(mem_timeout_err), (k >= TO) ? 32'd1 : 32'd0);
    end
    check("to_state", 32'(dbg_state), 32'(MEM_WAIT));
    // Asynchronous reset in the middle of the wait.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_outs", 32'(outs()), 32'(O_NONE));
    check("rst_mid_state", 32'(dbg_state), 32'(RUN));
    check("rst_mid_stall", 32'(stall_cycles), 32'd0);
    check("rst_mid_err", 32'(mem_timeout_err), 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    expect_cycle("post_rst_idle", O_NONE);

    // Saturation of both counters at all-ones.
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    for (int k = 0; k < 18; k++) expect_cycle($sformatf("sat_mw%0d", k), O_MW);
    dmem_ready = 1'b1;
    expect_cycle("sat_release", O_NONE);
    check("sat_stall_cnt", 32'(stall_cycles), 32'(SAT));
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    for (int k = 0; k < 17; k++) expect_cycle($sformatf("sat_br%0d", k), O_BR);
    check("sat_flush_cnt", 32'(flush_events), 32'(SAT));
    drive_idle();
    expect_cycle("final_idle", O_NONE);
    check("final_stall_cnt", 32'(stall_cycles), 32'(SAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage MIPS pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their `stall` and `flush` inputs. It also drives the PC write hold. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits under one fixed priority, and keeps saturating performance counters plus a sticky memory-timeout flag.

## Interface
- `MEM_TIMEOUT`, default 64: number of consecutive wait cycles after which `mem_timeout_err` sets.
- `CNT_W`, default 32: width of the performance counters.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `id_rs_addr` input 5: rs field of the instruction in ID.
- `id_rt_addr` input 5: rt field of the instruction in ID.
- `id_uses_rs` input 1: the ID instruction reads rs.
- `id_uses_rt` input 1: the ID instruction reads rt.
- `ex_mem_read` input 1: the ID/EX register holds a load.
- `ex_rt_addr` input 5: load destination (rt) held in the ID/EX register.
- `ex_branch_taken` input 1: EX resolved a taken branch or jump this cycle.
- `mem_access` input 1: the EX/MEM register holds a valid load or store.
- `dmem_ready` input 1: data memory completes the access this cycle.
- `pc_stall` output 1: hold the PC.
- `if_id_stall` output 1: hold the IF/ID register.
- `if_id_flush` output 1: clear the IF/ID register.
- `id_ex_stall` output 1: hold the ID/EX register.
- `id_ex_flush` output 1: clear the ID/EX register.
- `ex_mem_stall` output 1: hold the EX/MEM register.
- `mem_wb_flush` output 1: insert a bubble into MEM/WB.
- `stall_cycles` output CNT_W: count of cycles with `pc_stall`=1, saturating.
- `flush_events` output CNT_W: count of taken-branch flushes, saturating.
- `mem_timeout_err` output 1: sticky; set on timeout, cleared only by reset.

## Operation
- FSM states: RUN and MEM_WAIT.
  - RUN → MEM_WAIT when `mem_access`=1 and `dmem_ready`=0.
  - MEM_WAIT → RUN on the cycle `dmem_ready`=1.
  - MEM_WAIT otherwise holds.
- Memory wait:
  - Active when in MEM_WAIT, or when in RUN with `mem_access`=1 and `dmem_ready`=0.
  - Asserts `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush`.
  - All other outputs are 0.
- Load-use hazard:
  - Condition: `ex_mem_read`=1, `ex_rt_addr`≠0, and either (`id_uses_rs` and `id_rs_addr`=`ex_rt_addr`) or (`id_uses_rt` and `id_rt_addr`=`ex_rt_addr`).
  - Response: `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1 (bubble into EX).
- Branch taken: `if_id_flush`=1 and `id_ex_flush`=1; `pc_stall`=0 so the PC loads the target.
- Priority: memory wait > branch taken > load-use > none.
  - Branch together with load-use: the branch response only. The squashed consumer needs no stall.
  - Branch during a memory wait: ignored. EX is frozen, so `ex_branch_taken` persists and is acted on in the release cycle.
- Release cycle (`dmem_ready`=1 in MEM_WAIT):
  - The memory-wait outputs drop.
  - Branch and load-use rules apply normally in the same cycle.
- Wait counter:
  - Counts cycles spent in MEM_WAIT; cleared on entry to RUN.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout_err` sets. The FSM keeps waiting and does not abort.
- Counters saturate at all-ones and never wrap.
- `flush_events` increments once per cycle in which the branch response is driven.
- The stall/flush decision is combinational from the current state and inputs: zero-cycle latency. State and counters are registered.

## Timing
- While `reset`=0:
  - State is RUN; wait counter, `stall_cycles`, `flush_events` and `mem_timeout_err` are 0.
  - All stall/flush outputs are forced to 0.
- Reset asserted mid-wait returns the FSM to RUN immediately (asynchronously). The first edge after release evaluates fresh inputs.
- A load-use stall lasts exactly one cycle. On the next edge the load moves to MEM, `ex_mem_read` becomes 0 and the condition clears.
- A memory wait of N cycles with `dmem_ready` low:
  - Stalls for N+1 cycles: N cycles low plus the first cycle, in which the request is seen not ready.
  - Exception: the first-cycle stall is 0 if `dmem_ready` is high the same cycle as `mem_access`.
- `mem_timeout_err` rises on the edge where the wait counter equals `MEM_TIMEOUT`.

## Structure
- Shared package `hazard_pkg` contains:
  - The state enum (RUN, MEM_WAIT).
  - `REG_ZERO` = 5'd0.
  - A register-address width constant of 5.
- One sub-module, `load_use_detector`, is natural: combinational compare of the ID sources against the EX load destination, producing a 1-bit hazard flag.

## Test plan
- Load-use: ID/EX holds `lw $5`; ID holds `add` with rs=5 → one cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1, then all 0; `stall_cycles`=1.
- Load to $0 with an ID consumer of rs=0 → no stall.
- Branch with load-use: `ex_branch_taken`=1 while the load-use condition is true → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0; `flush_events`=1.
- Memory wait: `mem_access`=1 with `dmem_ready` low for 3 cycles, then high → 4 cycles of the full memory stall with `mem_wb_flush`=1; release cycle all stalls 0; state back to RUN.
- Branch during wait: `ex_branch_taken`=1 during a 2-cycle wait → no flush while waiting; flush asserted exactly in the release cycle.
- Timeout and reset: `MEM_TIMEOUT`=4, `dmem_ready` held low for 6 cycles → `mem_timeout_err` sets after the 4th MEM_WAIT cycle and stays set. Then assert `reset` mid-wait → outputs and counters 0, state RUN.
